i2c_slave_single_byte: RTL and testbench
========================================

I2C_SLAVE_SINGLE_BYTE -- requirements
Module: i2c_slave_single_byte

Interface
REQ-001 Parameter: SLAVE_ADDR, 7'h51, 7-bit address this target responds to.
REQ-002 r_Clock  input  1  system clock (50 MHz), all logic on rising edge.
REQ-003 r_Reset  input  1  reset, asynchronous, active-high.
REQ-004 i_Scl  input  1  bus SCL level, asynchronous to r_Clock.
REQ-005 i_Sda  input  1  bus SDA level, asynchronous to r_Clock.
REQ-006 o_Sda_Low  output  1  1 = pull SDA low (open-drain enable); 0 = release.
REQ-007 i_Tx_Byte  input  8  byte returned to the master on read; sampled at each byte load.
REQ-008 o_Rx_Byte  output  8  last data byte written by the master.
REQ-009 o_Rx_Valid  output  1  one-cycle pulse when o_Rx_Byte is updated.
REQ-010 o_Tx_Done  output  1  one-cycle pulse when the master's ACK/NACK for a read byte is sampled.
REQ-011 o_Busy  output  1  1 from address match until STOP, NACKed read, or new START.
REQ-012 o_Stop  output  1  one-cycle pulse on every detected STOP.

Function
REQ-013 SHALL pass i_Scl/i_Sda through 2-flop synchronizers; all detection uses the synchronized values and their 1-cycle-delayed copies.
REQ-014 SHALL detect START as SDA 1->0 with SCL high in both samples, and STOP as SDA 0->1 with SCL high in both samples.
REQ-015 SHALL sample SDA only on the synchronized SCL rising edge and change o_Sda_Low only on the synchronized SCL falling edge.
REQ-016 States: IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, ACK_RD.
REQ-017 IDLE: o_Sda_Low=0; on START -> ADDR, bit counter = 7.
REQ-018 ADDR: shift in 8 bits MSB first; after bit 0 -> ACK_ADDR if [7:1]==SLAVE_ADDR, else -> IDLE without ACK.
REQ-019 ACK_ADDR: drive o_Sda_Low=1 from the next SCL fall through the following SCL fall; set o_Busy=1.
REQ-019a ACK_ADDR exit: R/W=0 -> WR_DATA; R/W=1 -> load i_Tx_Byte into the shift register -> RD_DATA.
REQ-020 WR_DATA: shift in 8 bits; on the 8th SCL rise, update o_Rx_Byte and pulse o_Rx_Valid -> ACK_WR.
REQ-021 ACK_WR: ACK as in REQ-019, then -> WR_DATA for the next byte; multi-byte writes are unlimited.
REQ-022 RD_DATA: on each SCL fall, o_Sda_Low = ~shift[MSB], then shift left; the first bit is driven on the SCL fall that ends the address ACK.
REQ-023 RD_DATA exit: after 8 bits, release SDA on the next SCL fall -> ACK_RD.
REQ-024 ACK_RD: sample SDA on SCL rise and pulse o_Tx_Done.
REQ-024a ACK_RD on 0 (ACK): reload i_Tx_Byte -> RD_DATA.
REQ-024b ACK_RD on 1 (NACK): -> IDLE, o_Busy=0.
REQ-025 STOP in any state -> IDLE, o_Sda_Low=0 in the same cycle, o_Busy=0, pulse o_Stop.
REQ-026 START in any non-IDLE state (repeated start) -> ADDR, o_Sda_Low=0, o_Busy=0 until the next match.
REQ-027 START/STOP detection has priority over the SCL-edge actions of the same cycle.
REQ-028 Latency: o_Rx_Valid asserts 3 r_Clock cycles after the 8th data SCL rise at the i_Scl pin.

Reset
REQ-029 r_Reset asserted SHALL immediately force the following, regardless of bus activity:
- state IDLE
- o_Sda_Low=0, o_Rx_Byte=8'h00
- o_Rx_Valid=0, o_Tx_Done=0, o_Busy=0, o_Stop=0
- synchronizer flops = 1
REQ-030 After reset release mid-transfer, SHALL ignore bus activity until the next START.

Configuration
REQ-031 Macro I2C_SLAVE_GLITCH_FILTER_EN: when defined, SHALL insert a 3-sample majority filter on synchronized SCL and SDA before detection.
- Effect: single-cycle glitches are rejected; REQ-028 latency becomes 5 cycles.
- When undefined: no filter, REQ-028 latency as stated.

Verification
REQ-032 Write 0x51+W, data 0xAC, STOP -> ACK on both 9th clocks, o_Rx_Byte=0xAC, exactly one o_Rx_Valid pulse, one o_Stop pulse, o_Busy returns 0.
REQ-033 Address 0x50+W -> SDA never driven low, no o_Rx_Valid, o_Busy stays 0.
REQ-034 i_Tx_Byte=0x5A, 0x51+R, master NACK -> SDA bits 0,1,0,1,1,0,1,0 at SCL rises, one o_Tx_Done, state IDLE.
REQ-035 Read with master ACK then NACK, i_Tx_Byte changed 0x5A->0x3C between bytes -> second byte 0x3C.
REQ-036 Write 0x51+W, 0x12, repeated START, 0x51+R -> o_Rx_Byte=0x12, then read data driven.
REQ-036a Assert r_Reset during the 4th bit of a read byte -> o_Sda_Low=0 immediately.
REQ-037 Macro defined, 1-cycle low pulse on i_Scl during a data bit -> no extra bit shifted, o_Rx_Byte correct.
REQ-037a Macro undefined, same 1-cycle pulse -> pulse counted as an SCL edge.

Source files
------------

// File: rtl/i2c_slave_single_byte.sv
// ---------------------------------------------------------------------------
// i2c_slave_single_byte
// I2C target at a fixed 7-bit address. Accepts unlimited-length writes
// (each data byte is presented on o_Rx_Byte with an o_Rx_Valid pulse) and
// serves reads from i_Tx_Byte, which is sampled each time a read byte is
// loaded. SCL/SDA are oversampled on r_Clock. This block never stretches
// SCL.
//
// Build option:
//   I2C_SLAVE_GLITCH_FILTER_EN - adds a 3-sample majority filter on the
//   synchronized SCL/SDA. Single-cycle glitches are rejected, and two
//   cycles are added to the detection latency.
//
// Ports:
//   r_Clock     system clock; all logic runs on its rising edge
//   r_Reset     asynchronous reset, active high
//   i_Scl       SCL level from the bus pin (asynchronous)
//   i_Sda       SDA level from the bus pin (asynchronous)
//   o_Sda_Low   1 = pull SDA low (open-drain enable), 0 = release
//   i_Tx_Byte   byte returned to the master on a read
//   o_Rx_Byte   last data byte written by the master
//   o_Rx_Valid  one-cycle pulse when o_Rx_Byte is updated
//   o_Tx_Done   one-cycle pulse when the master's ACK/NACK is sampled
//   o_Busy      high from address match until STOP, NACKed read or START
//   o_Stop      one-cycle pulse on every detected STOP
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for START; SDA released
// ADDR     | shifting in the address byte and the R/W bit
// ACK_ADDR | acknowledging our address
// WR_DATA  | shifting in a byte written by the master
// ACK_WR   | acknowledging a written byte
// RD_DATA  | driving a read byte, MSB first
// ACK_RD   | SDA released; waiting to sample the master's ACK/NACK
// ---------------------------------------------------------------------------
module i2c_slave_single_byte #(
  parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
  input  logic       r_Clock,
  input  logic       r_Reset,
  input  logic       i_Scl,
  input  logic       i_Sda,
  output logic       o_Sda_Low,
  input  logic [7:0] i_Tx_Byte,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Tx_Done,
  output logic       o_Busy,
  output logic       o_Stop
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, ACK_RD
  } state_t;

  // Two-flop synchronizers. They reset to 1, the idle level of the bus.
  logic scl_meta, scl_sync, sda_meta, sda_sync;

  always_ff @(posedge r_Clock or posedge r_Reset) begin
    if (r_Reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      scl_meta <= i_Scl;
      scl_sync <= scl_meta;
      sda_meta <= i_Sda;
      sda_sync <= sda_meta;
    end
  end

  logic scl_s, sda_s;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // The majority vote is registered. Together with the two history
  // samples, this gives the two cycles of extra latency.
  logic [1:0] scl_hist, sda_hist;
  logic       scl_filt, sda_filt;

  always_ff @(posedge r_Clock or posedge r_Reset) begin
    if (r_Reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync};
      sda_hist <= {sda_hist[0], sda_sync};
      scl_filt <= (scl_sync & scl_hist[0]) | (scl_sync & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[1]);
      sda_filt <= (sda_sync & sda_hist[0]) | (sda_sync & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[1]);
    end
  end

  assign scl_s = scl_filt;
  assign sda_s = sda_filt;
`else
  assign scl_s = scl_sync;
  assign sda_s = sda_sync;
`endif

  logic scl_d, sda_d;

  always_ff @(posedge r_Clock or posedge r_Reset) begin
    if (r_Reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [7:0] shift_q, shift_n;
  logic       rw_q, rw_n;
  // Low during the first SCL fall of an ACK slot (start driving), high
  // during the second (release and move on).
  logic       ack_phase_q, ack_phase_n;
  logic       sda_low_n, busy_n, rx_valid_n, tx_done_n, stop_n;
  logic [7:0] rx_byte_n;
  logic [7:0] shift_in;

  assign shift_in = {shift_q[6:0], sda_s};

  always_ff @(posedge r_Clock or posedge r_Reset) begin
    if (r_Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      o_Sda_Low   <= 1'b0;
      o_Rx_Byte   <= 8'h00;
      o_Rx_Valid  <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_Busy      <= 1'b0;
      o_Stop      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      shift_q     <= shift_n;
      rw_q        <= rw_n;
      ack_phase_q <= ack_phase_n;
      o_Sda_Low   <= sda_low_n;
      o_Rx_Byte   <= rx_byte_n;
      o_Rx_Valid  <= rx_valid_n;
      o_Tx_Done   <= tx_done_n;
      o_Busy      <= busy_n;
      o_Stop      <= stop_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    shift_n     = shift_q;
    rw_n        = rw_q;
    ack_phase_n = ack_phase_q;
    sda_low_n   = o_Sda_Low;
    rx_byte_n   = o_Rx_Byte;
    busy_n      = o_Busy;
    rx_valid_n  = 1'b0;
    tx_done_n   = 1'b0;
    stop_n      = 1'b0;

    // Bus conditions take priority over any SCL edge in the same cycle.
    if (stop_det) begin
      state_n     = IDLE;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
      stop_n      = 1'b1;
      ack_phase_n = 1'b0;
    end else if (start_det) begin
      state_n     = ADDR;
      cnt_n       = 4'd7;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
      ack_phase_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_low_n = 1'b0;

        ADDR: if (scl_rise) begin
          shift_n = shift_in;
          if (cnt_q == 4'd0) begin
            if (shift_in[7:1] == SLAVE_ADDR) begin
              state_n = ACK_ADDR;
              busy_n  = 1'b1;
              rw_n    = shift_in[0];
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt_q - 4'd1;
          end
        end

        ACK_ADDR: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_low_n   = 1'b1;
            ack_phase_n = 1'b1;
          end else begin
            ack_phase_n = 1'b0;
            cnt_n       = 4'd7;
            if (rw_q) begin
              // The fall that ends the ACK also puts the first read bit out.
              state_n   = RD_DATA;
              sda_low_n = ~i_Tx_Byte[7];
              shift_n   = {i_Tx_Byte[6:0], 1'b0};
            end else begin
              state_n   = WR_DATA;
              sda_low_n = 1'b0;
            end
          end
        end

        WR_DATA: if (scl_rise) begin
          shift_n = shift_in;
          if (cnt_q == 4'd0) begin
            rx_byte_n  = shift_in;
            rx_valid_n = 1'b1;
            state_n    = ACK_WR;
          end else begin
            cnt_n = cnt_q - 4'd1;
          end
        end

        ACK_WR: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_low_n   = 1'b1;
            ack_phase_n = 1'b1;
          end else begin
            ack_phase_n = 1'b0;
            sda_low_n   = 1'b0;
            cnt_n       = 4'd7;
            state_n     = WR_DATA;
          end
        end

        // cnt_q holds the number of bits still to be driven.
        RD_DATA: if (scl_fall) begin
          if (cnt_q != 4'd0) begin
            sda_low_n = ~shift_q[7];
            shift_n   = {shift_q[6:0], 1'b0};
            cnt_n     = cnt_q - 4'd1;
          end else begin
            sda_low_n = 1'b0;
            state_n   = ACK_RD;
          end
        end

        ACK_RD: if (scl_rise) begin
          tx_done_n = 1'b1;
          if (!sda_s) begin
            state_n = RD_DATA;
            shift_n = i_Tx_Byte;
            cnt_n   = 4'd8;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_single_byte
// Bus-level I2C master model driving the target. Written bytes are pushed
// into a scoreboard queue and popped by a monitor on o_Rx_Valid. Read data,
// ACK bits and pulse counts are checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_i2c_slave_single_byte;

  localparam int QTR = 8;
  localparam logic [6:0] ADDR = 7'h51;

  logic       r_Clock = 1'b0;
  logic       r_Reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       o_Sda_Low;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Valid, o_Tx_Done, o_Busy, o_Stop;

  assign sda_bus = sda_m & ~o_Sda_Low;

  i2c_slave_single_byte #(.SLAVE_ADDR(ADDR)) dut (
    .r_Clock   (r_Clock),
    .r_Reset   (r_Reset),
    .i_Scl     (scl),
    .i_Sda     (sda_bus),
    .o_Sda_Low (o_Sda_Low),
    .i_Tx_Byte (i_Tx_Byte),
    .o_Rx_Byte (o_Rx_Byte),
    .o_Rx_Valid(o_Rx_Valid),
    .o_Tx_Done (o_Tx_Done),
    .o_Busy    (o_Busy),
    .o_Stop    (o_Stop)
  );

  always #10 r_Clock = ~r_Clock;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int rx_valid_cnt = 0;
  int tx_done_cnt  = 0;
  int stop_cnt     = 0;
  int exp_stops    = 0;
  logic [7:0] exp_rx[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor, sampling on the inactive clock edge.
  always @(negedge r_Clock) begin
    if (o_Rx_Valid) begin
      rx_valid_cnt++;
      if (exp_rx.size() == 0) check("rx_unexpected_pulse", 0, 1);
      else check("rx_byte", int'(o_Rx_Byte), int'(exp_rx.pop_front()));
    end
    if (o_Tx_Done) tx_done_cnt++;
    if (o_Stop)    stop_cnt++;
  end

  task automatic wait_q();
    repeat (QTR) @(negedge r_Clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
    exp_stops++;
    check("stop_pulses", stop_cnt, exp_stops);
    check("busy_after_stop", int'(o_Busy), 0);
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic seen);
    sda_m = b; wait_q();
    scl   = 1'b1; wait_q();
    seen  = sda_bus;
    if (glitch) begin
      scl = 1'b0;
      @(negedge r_Clock);
      scl = 1'b1;
    end
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_pos, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], (7 - i) == glitch_pos, s);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input bit mack, input logic [7:0] next_tx, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, 1'b0, s);
      b = {b[6:0], s};
    end
    i_Tx_Byte = next_tx;
    clock_bit(!mack, 1'b0, s);
  endtask

  // Transaction-level reference: a matching address ACKs every written byte
  // and returns each read byte as i_Tx_Byte stood when that byte was loaded;
  // a non-matching address leaves the bus released throughout.
  task automatic xact(input logic [6:0] a, input bit rw, input int n);
    bit match;
    logic ack;
    logic [7:0] d, got, txv, nxt;
    int rv0, td0;
    match = (a == ADDR);
    rv0 = rx_valid_cnt;
    td0 = tx_done_cnt;
    txv = 8'($urandom);
    i_Tx_Byte = txv;
    i2c_start();
    write_byte({a, rw}, -1, ack);
    check("addr_ack", int'(ack), match ? 0 : 1);
    check("busy_after_addr", int'(o_Busy), match ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        d = 8'($urandom);
        if (match) exp_rx.push_back(d);
        write_byte(d, -1, ack);
        check("data_ack", int'(ack), match ? 0 : 1);
      end else begin
        nxt = 8'($urandom);
        read_byte(i < n - 1, nxt, got);
        check("read_data", int'(got), match ? int'(txv) : 32'hFF);
        txv = nxt;
      end
    end
    if (rw) check("busy_after_nack", int'(o_Busy), 0);
    i2c_stop();
    check("rx_valid_count", rx_valid_cnt - rv0, (match && !rw) ? n : 0);
    check("tx_done_count", tx_done_cnt - td0, (match && rw) ? n : 0);
  endtask

  initial begin
    logic ack, s;
    logic [7:0] got, gd;
    int td0, rv0;

    repeat (5) @(negedge r_Clock);
    check("rst_sda_low", int'(o_Sda_Low), 0);
    check("rst_rx_byte", int'(o_Rx_Byte), 0);
    check("rst_busy", int'(o_Busy), 0);
    r_Reset = 1'b0;
    repeat (5) @(negedge r_Clock);
    check("post_rst_pulses", int'({o_Rx_Valid, o_Tx_Done, o_Stop}), 0);

    // Write 0xAC to our address.
    i2c_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    check("wr_addr_ack", int'(ack), 0);
    exp_rx.push_back(8'hAC);
    rv0 = rx_valid_cnt;
    write_byte(8'hAC, -1, ack);
    check("wr_data_ack", int'(ack), 0);
    check("wr_rx_byte", int'(o_Rx_Byte), 32'hAC);
    i2c_stop();
    check("wr_one_valid", rx_valid_cnt - rv0, 1);

    // Wrong address: everything fully ignored.
    xact(7'h50, 1'b0, 1);

    // Read 0x5A, master NACK.
    td0 = tx_done_cnt;
    i_Tx_Byte = 8'h5A;
    i2c_start();
    write_byte({ADDR, 1'b1}, -1, ack);
    check("rd_addr_ack", int'(ack), 0);
    read_byte(1'b0, 8'h00, got);
    check("rd_5a", int'(got), 32'h5A);
    check("rd_idle_sda", int'(o_Sda_Low), 0);
    check("rd_one_done", tx_done_cnt - td0, 1);
    i2c_stop();

    // Two-byte read, i_Tx_Byte changed between bytes.
    i_Tx_Byte = 8'h5A;
    i2c_start();
    write_byte({ADDR, 1'b1}, -1, ack);
    read_byte(1'b1, 8'h3C, got);
    check("rd2_first", int'(got), 32'h5A);
    read_byte(1'b0, 8'h00, got);
    check("rd2_second", int'(got), 32'h3C);
    i2c_stop();

    // Write 0x12, repeated START, then read.
    i2c_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    exp_rx.push_back(8'h12);
    write_byte(8'h12, -1, ack);
    i_Tx_Byte = 8'hC3;
    i2c_start();
    check("rs_busy_cleared", int'(o_Busy), 0);
    check("rs_rx_hold", int'(o_Rx_Byte), 32'h12);
    write_byte({ADDR, 1'b1}, -1, ack);
    check("rs_addr_ack", int'(ack), 0);
    read_byte(1'b0, 8'h00, got);
    check("rs_read", int'(got), 32'hC3);
    i2c_stop();

    // Reset while the 4th bit of a read byte (a zero) is on the bus.
    i_Tx_Byte = 8'h00;
    i2c_start();
    write_byte({ADDR, 1'b1}, -1, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
    check("pre_rst_driving", int'(o_Sda_Low), 1);
    r_Reset = 1'b1;
    #1;
    check("rst_sda_release", int'(o_Sda_Low), 0);
    check("rst_busy_clear", int'(o_Busy), 0);
    repeat (3) @(negedge r_Clock);
    r_Reset = 1'b0;
    repeat (3) @(negedge r_Clock);
    clock_bit(1'b1, 1'b0, s);
    check("post_rst_ignored", int'(s), 1);
    i2c_stop();

    // One-cycle SCL low pulse inside a data bit.
    gd = 8'hB4;
    i2c_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    rv0 = rx_valid_cnt;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_rx.push_back(gd);
    write_byte(gd, 2, ack);
    check("glitch_ack", int'(ack), 0);
`else
    exp_rx.push_back({gd[7:5], gd[5:1]});
    write_byte(gd, 2, ack);
    check("glitch_ack", int'(ack), 1);
`endif
    i2c_stop();
    check("glitch_one_valid", rx_valid_cnt - rv0, 1);

    // Randomized transactions.
    for (int t = 0; t < 14; t++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 0) ? ADDR : 7'($urandom);
      xact(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end

    check("rx_queue_drained", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
